// File: rtl/wide_rd_arb_pkg.sv
// -----------------------------------------------------------------------------
// wide_rd_arb_pkg
//   Shared definitions for the wide read-port arbiter.
//   - WORD_W   : data width of each memory read port
//   - MAX_REQ  : largest requester count the helpers are sized for
//   - IDW      : requester id width at MAX_REQ (the top trims to its own width)
//   - rsp_slot_t : one stage of the response pipeline {valid, id}
//   - rr_pick  : round-robin find-first, returns {found, idx}
// -----------------------------------------------------------------------------
package wide_rd_arb_pkg;

  localparam int WORD_W  = 32;
  localparam int MAX_REQ = 8;
  localparam int IDW     = 3;

  typedef struct packed {
    logic           valid;
    logic [IDW-1:0] id;
  } rsp_slot_t;

  // Walks the requester ring starting at ptr and returns the first requester
  // with its bit set. Only the first n positions take part, and the walk
  // index wraps by compare-and-clear so non-power-of-two counts behave.
  function automatic logic [IDW:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                           input logic [IDW-1:0]     ptr,
                                           input int                 n);
    logic           found;
    logic [IDW-1:0] idx;
    logic [IDW-1:0] cand;
    found = 1'b0;
    idx   = '0;
    cand  = ptr;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (i < n) begin
        if (!found && req[cand]) begin
          found = 1'b1;
          idx   = cand;
        end
        if (cand == IDW'(n - 1)) begin
          cand = '0;
        end else begin
          cand = cand + IDW'(1);
        end
      end
    end
    return {found, idx};
  endfunction

endpackage

// File: rtl/wide_rd_port_arbiter_rr_priority_pick.sv
// -----------------------------------------------------------------------------
// rr_priority_pick
//   Combinational rotate-find-first used by the read-port arbiter.
//   Ports:
//     i_req   : request vector, one bit per requester
//     i_ptr   : index at which the search starts (0..N_REQ-1)
//     o_found : at least one request is present
//     o_idx   : index of the first requester at or after i_ptr (with wrap)
// -----------------------------------------------------------------------------
module rr_priority_pick
  import wide_rd_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [ID_W-1:0]  i_ptr,
  output logic             o_found,
  output logic [ID_W-1:0]  o_idx
);

  logic [MAX_REQ-1:0] req_ext;
  logic [IDW-1:0]     ptr_ext;

  // Widen to the package helper's fixed sizes; unused upper requesters stay 0
  always_comb begin
    req_ext              = '0;
    req_ext[N_REQ-1:0]   = i_req;
    ptr_ext              = '0;
    ptr_ext[ID_W-1:0]    = i_ptr;
  end

  // The walk is limited to N_REQ positions, so "found" is just any request
  assign o_found = |i_req;
  assign o_idx   = ID_W'(rr_pick(req_ext, ptr_ext, N_REQ));

endmodule

// File: rtl/wide_rd_port_arbiter.sv
// -----------------------------------------------------------------------------
// wide_rd_port_arbiter
//   Round-robin arbiter sharing one dual-read-port, 32-bit-wide input RAM
//   between N_REQ requesters. One grant per cycle; the winner's two addresses
//   go to the RAM together and the returned word pair is tagged back to the
//   winner RD_LAT cycles later.
//
//   Ports:
//     clk, rst            : clock, asynchronous active-high reset
//     i_en                : arbitration enable (0 blocks new grants)
//     i_req               : per-requester request, held until granted
//     i_raddr0/i_raddr1   : packed addresses, requester k at [k*AW +: AW]
//     o_gnt               : one-hot combinational grant
//     o_rvalid            : one-hot response valid
//     o_rdata0/o_rdata1   : broadcast read data (passthrough of RAM data)
//     mem_raddr0/1        : RAM addresses
//     mem_rdata0/1        : RAM read data
//     o_busy              : any request pending or any response in flight
//
//   Optional (macro WIDE_RD_ARB_STATS_EN):
//     i_stats_clr         : synchronous clear of the counters
//     o_grant_cnt         : per-requester saturating grant counters, packed
//     o_stall_cnt         : cycles with at least one waiting requester
// -----------------------------------------------------------------------------
module wide_rd_port_arbiter
  import wide_rd_arb_pkg::*;
#(
  parameter int AW     = 10,
  parameter int N_REQ  = 4,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_en,
  input  logic [N_REQ-1:0]    i_req,
  input  logic [N_REQ*AW-1:0] i_raddr0,
  input  logic [N_REQ*AW-1:0] i_raddr1,
  output logic [N_REQ-1:0]    o_gnt,
  output logic [N_REQ-1:0]    o_rvalid,
  output logic [WORD_W-1:0]   o_rdata0,
  output logic [WORD_W-1:0]   o_rdata1,
  output logic [AW-1:0]       mem_raddr0,
  output logic [AW-1:0]       mem_raddr1,
  input  logic [WORD_W-1:0]   mem_rdata0,
  input  logic [WORD_W-1:0]   mem_rdata1,
  output logic                o_busy
`ifdef WIDE_RD_ARB_STATS_EN
  ,
  input  logic                i_stats_clr,
  output logic [N_REQ*32-1:0] o_grant_cnt,
  output logic [31:0]         o_stall_cnt
`endif
);

  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [ID_W-1:0] rr_ptr;
  logic            pick_found;
  logic [ID_W-1:0] win_idx;
  logic            gnt_valid;
  logic [AW-1:0]   win_addr0;
  logic [AW-1:0]   win_addr1;
  logic [AW-1:0]   last_addr0;
  logic [AW-1:0]   last_addr1;
  rsp_slot_t       rsp_pipe [RD_LAT];
  logic            pipe_busy;

  rr_priority_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .i_req   (i_req),
    .i_ptr   (rr_ptr),
    .o_found (pick_found),
    .o_idx   (win_idx)
  );

  // Grants are suppressed while reset is asserted so every output reads 0
  // immediately, not just after the next edge.
  assign gnt_valid = i_en & pick_found & ~rst;

  always_comb begin
    o_gnt = '0;
    if (gnt_valid) begin
      o_gnt[win_idx] = 1'b1;
    end
  end

  assign win_addr0 = i_raddr0[int'(win_idx)*AW +: AW];
  assign win_addr1 = i_raddr1[int'(win_idx)*AW +: AW];

  // Outside a grant cycle the RAM sees the last granted pair, so its address
  // lines only move when a new read is actually issued.
  assign mem_raddr0 = gnt_valid ? win_addr0 : last_addr0;
  assign mem_raddr1 = gnt_valid ? win_addr1 : last_addr1;

  // Pointer moves one past the winner; wrap by compare-and-clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (gnt_valid) begin
      if (win_idx == ID_W'(N_REQ - 1)) begin
        rr_ptr <= '0;
      end else begin
        rr_ptr <= win_idx + ID_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_addr0 <= '0;
      last_addr1 <= '0;
    end else if (gnt_valid) begin
      last_addr0 <= win_addr0;
      last_addr1 <= win_addr1;
    end
  end

  // Response tag pipeline: mirrors the RAM latency so the tag reaches the
  // last stage in the same cycle as the data it belongs to. Reset empties it,
  // which drops any read that was in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        rsp_pipe[i] <= '0;
      end
    end else begin
      rsp_pipe[0].valid <= gnt_valid;
      rsp_pipe[0].id    <= IDW'(win_idx);
      for (int i = 1; i < RD_LAT; i++) begin
        rsp_pipe[i] <= rsp_pipe[i-1];
      end
    end
  end

  always_comb begin
    o_rvalid = '0;
    if (rsp_pipe[RD_LAT-1].valid) begin
      o_rvalid = N_REQ'(1) << rsp_pipe[RD_LAT-1].id;
    end
  end

  assign o_rdata0 = mem_rdata0;
  assign o_rdata1 = mem_rdata1;

  always_comb begin
    pipe_busy = 1'b0;
    for (int i = 0; i < RD_LAT; i++) begin
      pipe_busy = pipe_busy | rsp_pipe[i].valid;
    end
  end

  assign o_busy = ~rst & ((|i_req) | pipe_busy);

`ifdef WIDE_RD_ARB_STATS_EN
  logic [31:0] grant_cnt [N_REQ];
  logic [31:0] stall_cnt;
  logic        any_stall;

  assign any_stall = |(i_req & ~o_gnt);

  // Grant counters saturate; clear wins over a same-cycle increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_REQ; k++) begin
        grant_cnt[k] <= '0;
      end
      stall_cnt <= '0;
    end else if (i_stats_clr) begin
      for (int k = 0; k < N_REQ; k++) begin
        grant_cnt[k] <= '0;
      end
      stall_cnt <= '0;
    end else begin
      for (int k = 0; k < N_REQ; k++) begin
        if (o_gnt[k] && (grant_cnt[k] != 32'hFFFF_FFFF)) begin
          grant_cnt[k] <= grant_cnt[k] + 32'd1;
        end
      end
      if (any_stall) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end

  always_comb begin
    o_grant_cnt = '0;
    for (int k = 0; k < N_REQ; k++) begin
      o_grant_cnt[k*32 +: 32] = grant_cnt[k];
    end
  end

  assign o_stall_cnt = stall_cnt;
`endif

endmodule

// File: tb/tb_wide_rd_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wide_rd_port_arbiter
//   Directed bench for wide_rd_port_arbiter. Two instances share the request
//   inputs: dut (RD_LAT=1) with a one-cycle RAM model, and dut3 (RD_LAT=3)
//   with its own reset for the latency / in-flight-drop scenario.
// -----------------------------------------------------------------------------
module tb_wide_rd_port_arbiter;

  localparam int AW = 10;
  localparam int N  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          rst3;
  logic          i_en;
  logic          stats_clr;
  logic [N-1:0]  req;
  logic [N*AW-1:0] ra0;
  logic [N*AW-1:0] ra1;

  logic [N-1:0]  gnt, rvalid;
  logic [31:0]   rd0, rd1, mem_rd0, mem_rd1;
  logic [AW-1:0] ma0, ma1;
  logic          busy;

  logic [N-1:0]  gnt3, rvalid3;
  logic [31:0]   rd0_3, rd1_3;
  logic [AW-1:0] ma0_3, ma1_3;
  logic          busy3;

`ifdef WIDE_RD_ARB_STATS_EN
  logic [N*32-1:0] gcnt, gcnt3;
  logic [31:0]     scnt, scnt3;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wide_rd_port_arbiter #(.AW(AW), .N_REQ(N), .RD_LAT(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_en       (i_en),
    .i_req      (req),
    .i_raddr0   (ra0),
    .i_raddr1   (ra1),
    .o_gnt      (gnt),
    .o_rvalid   (rvalid),
    .o_rdata0   (rd0),
    .o_rdata1   (rd1),
    .mem_raddr0 (ma0),
    .mem_raddr1 (ma1),
    .mem_rdata0 (mem_rd0),
    .mem_rdata1 (mem_rd1),
    .o_busy     (busy)
`ifdef WIDE_RD_ARB_STATS_EN
    ,
    .i_stats_clr (stats_clr),
    .o_grant_cnt (gcnt),
    .o_stall_cnt (scnt)
`endif
  );

  wide_rd_port_arbiter #(.AW(AW), .N_REQ(N), .RD_LAT(3)) dut3 (
    .clk        (clk),
    .rst        (rst3),
    .i_en       (i_en),
    .i_req      (req),
    .i_raddr0   (ra0),
    .i_raddr1   (ra1),
    .o_gnt      (gnt3),
    .o_rvalid   (rvalid3),
    .o_rdata0   (rd0_3),
    .o_rdata1   (rd1_3),
    .mem_raddr0 (ma0_3),
    .mem_raddr1 (ma1_3),
    .mem_rdata0 (32'h0),
    .mem_rdata1 (32'h0),
    .o_busy     (busy3)
`ifdef WIDE_RD_ARB_STATS_EN
    ,
    .i_stats_clr (stats_clr),
    .o_grant_cnt (gcnt3),
    .o_stall_cnt (scnt3)
`endif
  );

  function automatic logic [31:0] word0(input logic [AW-1:0] a);
    return 32'hA500_0000 | {22'h0, a};
  endfunction

  function automatic logic [31:0] word1(input logic [AW-1:0] a);
    return 32'h5A00_0000 | {22'h0, a};
  endfunction

  // One-cycle synchronous-read RAM model for the RD_LAT=1 instance
  always @(posedge clk) begin
    mem_rd0 <= word0(ma0);
    mem_rd1 <= word1(ma1);
  end

  task automatic set_addr(input int k, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    ra0[k*AW +: AW] = a0;
    ra1[k*AW +: AW] = a1;
  endtask

  task automatic test_reset();
    rst = 1'b1; rst3 = 1'b1; i_en = 1'b1; stats_clr = 1'b0;
    req = '0; ra0 = '0; ra1 = '0;
    #3;
    checks++; if (gnt !== 4'b0000) begin errors++; $display("[TB] FAIL reset_gnt: got %b want 0000", gnt); end
    checks++; if (rvalid !== 4'b0000) begin errors++; $display("[TB] FAIL reset_rvalid: got %b want 0000", rvalid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    checks++; if (ma0 !== 10'h000 || ma1 !== 10'h000) begin errors++; $display("[TB] FAIL reset_maddr: got %h/%h want 000/000", ma0, ma1); end
    req = 4'b0001; set_addr(0, 10'h3FF, 10'h3FE);
    #1;
    checks++; if (gnt !== 4'b0000 || busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_req_blocked: got gnt=%b busy=%b want 0000/0", gnt, busy); end
    checks++; if (ma0 !== 10'h000) begin errors++; $display("[TB] FAIL reset_req_maddr: got %h want 000", ma0); end
    req = '0;
    @(negedge clk); rst = 1'b0; rst3 = 1'b0;
  endtask

  task automatic test_all_req();
    for (int k = 0; k < N; k++) set_addr(k, 10'h100 + AW'(k), 10'h200 + AW'(k));
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); req = 4'b1111; #1;
      checks++; if (gnt !== (4'b0001 << (i % 4))) begin errors++; $display("[TB] FAIL all_gnt[%0d]: got %b want %b", i, gnt, 4'b0001 << (i % 4)); end
      checks++; if (ma0 !== (10'h100 + AW'(i % 4))) begin errors++; $display("[TB] FAIL all_maddr[%0d]: got %h want %h", i, ma0, 10'h100 + AW'(i % 4)); end
      if (i > 0) begin
        checks++; if (rvalid !== (4'b0001 << ((i - 1) % 4))) begin errors++; $display("[TB] FAIL all_rvalid[%0d]: got %b want %b", i, rvalid, 4'b0001 << ((i - 1) % 4)); end
      end
    end
    @(negedge clk); req = '0; #1;
    checks++; if (rvalid !== 4'b1000) begin errors++; $display("[TB] FAIL all_rvalid_last: got %b want 1000", rvalid); end
    checks++; if (rd0 !== word0(10'h103)) begin errors++; $display("[TB] FAIL all_rdata_last: got %h want %h", rd0, word0(10'h103)); end
`ifdef WIDE_RD_ARB_STATS_EN
    checks++; if (scnt !== 32'd8) begin errors++; $display("[TB] FAIL all_stall_cnt: got %0d want 8", scnt); end
    checks++; if (gcnt[0 +: 32] !== 32'd2) begin errors++; $display("[TB] FAIL all_grant_cnt0: got %0d want 2", gcnt[0 +: 32]); end
`endif
  endtask

  task automatic test_single();
    set_addr(0, 10'h005, 10'h015);
    @(negedge clk); req = 4'b0001; #1;
    checks++; if (gnt !== 4'b0001) begin errors++; $display("[TB] FAIL single_gnt: got %b want 0001", gnt); end
    checks++; if (ma0 !== 10'h005 || ma1 !== 10'h015) begin errors++; $display("[TB] FAIL single_maddr: got %h/%h want 005/015", ma0, ma1); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL single_busy: got %b want 1", busy); end
    @(negedge clk); req = '0; #1;
    checks++; if (rvalid !== 4'b0001) begin errors++; $display("[TB] FAIL single_rvalid: got %b want 0001", rvalid); end
    checks++; if (rd0 !== word0(10'h005) || rd1 !== word1(10'h015)) begin errors++; $display("[TB] FAIL single_rdata: got %h/%h want %h/%h", rd0, rd1, word0(10'h005), word1(10'h015)); end
    checks++; if (gnt !== 4'b0000 || ma0 !== 10'h005) begin errors++; $display("[TB] FAIL single_hold: got gnt=%b maddr=%h want 0000/005", gnt, ma0); end
    @(negedge clk); #1;
    checks++; if (busy !== 1'b0 || rvalid !== 4'b0000) begin errors++; $display("[TB] FAIL single_idle: got busy=%b rvalid=%b want 0/0000", busy, rvalid); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); req = 4'b0010; set_addr(1, 10'h030 + AW'(i), 10'h040 + AW'(i)); #1;
      checks++; if (gnt !== 4'b0010) begin errors++; $display("[TB] FAIL b2b_gnt[%0d]: got %b want 0010", i, gnt); end
      checks++; if (ma0 !== (10'h030 + AW'(i))) begin errors++; $display("[TB] FAIL b2b_maddr[%0d]: got %h want %h", i, ma0, 10'h030 + AW'(i)); end
      if (i > 0) begin
        checks++; if (rvalid !== 4'b0010 || rd0 !== word0(10'h030 + AW'(i - 1))) begin errors++; $display("[TB] FAIL b2b_rsp[%0d]: got %b/%h want 0010/%h", i, rvalid, rd0, word0(10'h030 + AW'(i - 1))); end
      end
    end
    @(negedge clk); req = '0; #1;
    checks++; if (rvalid !== 4'b0010 || rd1 !== word1(10'h042)) begin errors++; $display("[TB] FAIL b2b_rsp_last: got %b/%h want 0010/%h", rvalid, rd1, word1(10'h042)); end
  endtask

  task automatic test_wrap();
    // Pointer sits at 2 here; requester 0 must win by wrapping past 3
    set_addr(0, 10'h0AA, 10'h0BB);
    set_addr(1, 10'h111, 10'h122);
    @(negedge clk); req = 4'b0011; #1;
    checks++; if (gnt !== 4'b0001 || ma0 !== 10'h0AA) begin errors++; $display("[TB] FAIL wrap_gnt: got %b/%h want 0001/0aa", gnt, ma0); end
    @(negedge clk); req = 4'b0010; #1;
    checks++; if (gnt !== 4'b0010 || ma0 !== 10'h111) begin errors++; $display("[TB] FAIL wrap_next: got %b/%h want 0010/111", gnt, ma0); end
  endtask

  task automatic test_disable();
    set_addr(2, 10'h2CC, 10'h2DD);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); i_en = 1'b0; req = 4'b0100; #1;
      checks++; if (gnt !== 4'b0000 || busy !== 1'b1) begin errors++; $display("[TB] FAIL dis_gnt[%0d]: got gnt=%b busy=%b want 0000/1", i, gnt, busy); end
      checks++; if (ma0 !== 10'h111 || ma1 !== 10'h122) begin errors++; $display("[TB] FAIL dis_maddr[%0d]: got %h/%h want 111/122", i, ma0, ma1); end
      if (i == 0) begin
        checks++; if (rvalid !== 4'b0010) begin errors++; $display("[TB] FAIL dis_inflight: got %b want 0010", rvalid); end
      end
    end
    @(negedge clk); i_en = 1'b1; #1;
    checks++; if (gnt !== 4'b0100 || ma0 !== 10'h2CC) begin errors++; $display("[TB] FAIL dis_resume: got %b/%h want 0100/2cc", gnt, ma0); end
    @(negedge clk); req = '0; #1;
    checks++; if (rvalid !== 4'b0100) begin errors++; $display("[TB] FAIL dis_resume_rsp: got %b want 0100", rvalid); end
  endtask

  task automatic test_rd_lat3();
    @(negedge clk); rst3 = 1'b1;
    @(negedge clk); rst3 = 1'b0; req = 4'b0010; #1;
    checks++; if (gnt3 !== 4'b0010) begin errors++; $display("[TB] FAIL lat3_gnt: got %b want 0010", gnt3); end
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk); req = '0; #1;
      checks++; if (rvalid3 !== ((i == 3) ? 4'b0010 : 4'b0000)) begin errors++; $display("[TB] FAIL lat3_rvalid[%0d]: got %b want %b", i, rvalid3, (i == 3) ? 4'b0010 : 4'b0000); end
    end
    // Pointer now at 2: issue ids 1,2,3 back to back, then reset mid-flight
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); req = 4'b0010 << i; #1;
      checks++; if (gnt3 !== (4'b0010 << i)) begin errors++; $display("[TB] FAIL lat3_burst_gnt[%0d]: got %b want %b", i, gnt3, 4'b0010 << i); end
    end
    rst3 = 1'b1; #1;
    checks++; if (gnt3 !== 4'b0000 || rvalid3 !== 4'b0000 || busy3 !== 1'b0) begin errors++; $display("[TB] FAIL lat3_async_rst: got gnt=%b rvalid=%b busy=%b want 0000/0000/0", gnt3, rvalid3, busy3); end
    checks++; if (ma0_3 !== 10'h000 || ma1_3 !== 10'h000) begin errors++; $display("[TB] FAIL lat3_rst_maddr: got %h/%h want 000/000", ma0_3, ma1_3); end
    @(negedge clk); req = '0;
    @(negedge clk); rst3 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      checks++; if (rvalid3 !== 4'b0000 || busy3 !== 1'b0) begin errors++; $display("[TB] FAIL lat3_dropped[%0d]: got rvalid=%b busy=%b want 0000/0", i, rvalid3, busy3); end
    end
  endtask

`ifdef WIDE_RD_ARB_STATS_EN
  task automatic test_stats();
    @(negedge clk); req = '0; stats_clr = 1'b1;
    @(negedge clk); stats_clr = 1'b0; #1;
    checks++; if (gcnt[0 +: 32] !== 32'd0 || scnt !== 32'd0) begin errors++; $display("[TB] FAIL stats_clr: got %0d/%0d want 0/0", gcnt[0 +: 32], scnt); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); req = 4'b0001;
    end
    @(negedge clk); req = '0; #1;
    checks++; if (gcnt[0 +: 32] !== 32'd5) begin errors++; $display("[TB] FAIL stats_gcnt5: got %0d want 5", gcnt[0 +: 32]); end
    checks++; if (scnt !== 32'd0) begin errors++; $display("[TB] FAIL stats_nostall: got %0d want 0", scnt); end
    @(negedge clk); req = 4'b0001; stats_clr = 1'b1; #1;
    checks++; if (gnt !== 4'b0001) begin errors++; $display("[TB] FAIL stats_clr_gnt: got %b want 0001", gnt); end
    @(negedge clk); req = '0; stats_clr = 1'b0; #1;
    checks++; if (gcnt[0 +: 32] !== 32'd0) begin errors++; $display("[TB] FAIL stats_clr_priority: got %0d want 0", gcnt[0 +: 32]); end
  endtask
`endif

  initial begin
    test_reset();
    test_all_req();
    test_single();
    test_back_to_back();
    test_wrap();
    test_disable();
    test_rd_lat3();
`ifdef WIDE_RD_ARB_STATS_EN
    test_stats();
`endif
    @(negedge clk); req = '0;
    @(negedge clk); #1;
    checks++; if (busy !== 1'b0 || busy3 !== 1'b0) begin errors++; $display("[TB] FAIL final_idle: got busy=%b busy3=%b want 0/0", busy, busy3); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
